// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename status (busy, ROB tag).
// Optional macro REG_BYPASS_EN forwards a matching commit to the read ports in the same cycle.
module reg_status_file #(
    parameter int REG_ID_BIT    = 5,
    parameter int ROB_WIDTH_BIT = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     issue_en,
    input  logic [REG_ID_BIT-1:0]    issue_rd,
    input  logic [ROB_WIDTH_BIT-1:0] issue_rob_id,
    input  logic [REG_ID_BIT-1:0]    rs1,
    input  logic [REG_ID_BIT-1:0]    rs2,
    output logic [31:0]              rs1_val,
    output logic                     rs1_busy,
    output logic [ROB_WIDTH_BIT-1:0] rs1_tag,
    output logic [31:0]              rs2_val,
    output logic                     rs2_busy,
    output logic [ROB_WIDTH_BIT-1:0] rs2_tag,
    input  logic                     commit_en,
    input  logic [REG_ID_BIT-1:0]    commit_rd,
    input  logic [ROB_WIDTH_BIT-1:0] commit_rob_id,
    input  logic [31:0]              commit_value,
    input  logic                     flush_in
);

    localparam int NUM_REGS = 1 << REG_ID_BIT;

    typedef struct packed {
        logic [31:0]              val;
        logic                     busy;
        logic [ROB_WIDTH_BIT-1:0] tag;
    } read_t;

    logic [31:0]              regs [NUM_REGS];
    logic [NUM_REGS-1:0]      busy;
    logic [ROB_WIDTH_BIT-1:0] tag  [NUM_REGS];

    logic  commit_wr;
    logic  commit_hit;
    logic  issue_take;
    read_t rd1;
    read_t rd2;

    // A commit only releases the rename if it is still the newest producer of that register.
    assign commit_wr  = commit_en && (commit_rd != '0);
    assign commit_hit = commit_wr && busy[commit_rd] && (tag[commit_rd] == commit_rob_id);
    assign issue_take = issue_en && (issue_rd != '0) && !flush_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            // NOTE: the value array is reset explicitly because every index must read 0 after reset.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
                tag[i]  <= '0;
            end
            busy <= '0;
        end else if (rdy_in) begin
            if (commit_wr) begin
                regs[commit_rd] <= commit_value;
            end
            if (flush_in) begin
                busy <= '0;
            end else begin
                if (commit_hit) begin
                    busy[commit_rd] <= 1'b0;
                end
                // NOTE: the later non-blocking write wins, so an issue to the same rd overrides the release.
                if (issue_take) begin
                    busy[issue_rd] <= 1'b1;
                    tag[issue_rd]  <= issue_rob_id;
                end
            end
        end
    end

    function automatic read_t read_port(input logic [REG_ID_BIT-1:0] idx);
        read_t r;
        r = '0;
        if (idx != '0) begin
            r.val  = regs[idx];
            r.busy = busy[idx];
            r.tag  = tag[idx];
`ifdef REG_BYPASS_EN
            if (commit_hit && (commit_rd == idx)) begin
                r.val  = commit_value;
                r.busy = 1'b0;
            end
`endif
        end
        return r;
    endfunction

    assign rd1 = read_port(rs1);
    assign rd2 = read_port(rs2);

    assign rs1_val  = rd1.val;
    assign rs1_busy = rd1.busy;
    assign rs1_tag  = rd1.tag;
    assign rs2_val  = rd2.val;
    assign rs2_busy = rd2.busy;
    assign rs2_tag  = rd2.tag;

endmodule

// File: tb/tb_reg_status_file.sv
// Bench for reg_status_file: directed vectors, a per-cycle comparison against a
// rule-level model of the rename table, and hand-computed literal expectations.
`timescale 1ns/1ps
module tb_reg_status_file;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic [3:0]  issue_rob_id;
    logic [4:0]  rs1, rs2;
    logic [31:0] rs1_val, rs2_val;
    logic        rs1_busy, rs2_busy;
    logic [3:0]  rs1_tag, rs2_tag;
    logic        commit_en;
    logic [4:0]  commit_rd;
    logic [3:0]  commit_rob_id;
    logic [31:0] commit_value;
    logic        flush_in;

    int checks = 0;
    int errors = 0;
    bit model_ok = 1'b0;

    logic [31:0] m_val  [32];
    bit          m_busy [32];
    logic [3:0]  m_tag  [32];

    reg_status_file dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_en(issue_en), .issue_rd(issue_rd), .issue_rob_id(issue_rob_id),
        .rs1(rs1), .rs2(rs2),
        .rs1_val(rs1_val), .rs1_busy(rs1_busy), .rs1_tag(rs1_tag),
        .rs2_val(rs2_val), .rs2_busy(rs2_busy), .rs2_tag(rs2_tag),
        .commit_en(commit_en), .commit_rd(commit_rd), .commit_rob_id(commit_rob_id),
        .commit_value(commit_value), .flush_in(flush_in)
    );

    always #50 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: apply the architectural rules for one rising edge.
    always @(posedge clk_in) begin
        bit owner_retires;
        if (rst_in) begin
            for (int i = 0; i < 32; i++) begin
                m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0;
            end
        end else if (rdy_in) begin
            owner_retires = commit_en && commit_rd != 0 && m_busy[commit_rd]
                            && m_tag[commit_rd] == commit_rob_id;
            if (commit_en && commit_rd != 0) m_val[commit_rd] = commit_value;
            if (flush_in) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 0;
            end else begin
                if (owner_retires) m_busy[commit_rd] = 0;
                if (issue_en && issue_rd != 0) begin
                    m_busy[issue_rd] = 1;
                    m_tag[issue_rd]  = issue_rob_id;
                end
            end
        end
    end

    function automatic void exp_read(input logic [4:0] idx, output logic [31:0] v,
                                     output logic b, output logic [3:0] t);
        v = 0; b = 0; t = 0;
        if (idx != 0) begin
            v = m_val[idx]; b = m_busy[idx]; t = m_tag[idx];
`ifdef REG_BYPASS_EN
            if (commit_en && commit_rd == idx && m_busy[idx] && m_tag[idx] == commit_rob_id) begin
                v = commit_value; b = 0;
            end
`endif
        end
    endfunction

    always @(negedge clk_in) begin
        logic [31:0] ev;
        logic        eb;
        logic [3:0]  et;
        if (model_ok) begin
            exp_read(rs1, ev, eb, et);
            check("cmp_rs1_val", rs1_val, ev);
            check("cmp_rs1_busy", {31'b0, rs1_busy}, {31'b0, eb});
            if (eb) check("cmp_rs1_tag", {28'b0, rs1_tag}, {28'b0, et});
            exp_read(rs2, ev, eb, et);
            check("cmp_rs2_val", rs2_val, ev);
            check("cmp_rs2_busy", {31'b0, rs2_busy}, {31'b0, eb});
            if (eb) check("cmp_rs2_tag", {28'b0, rs2_tag}, {28'b0, et});
        end
    end

    task automatic idle();
        rst_in = 0; rdy_in = 1; flush_in = 0;
        issue_en = 0; issue_rd = 0; issue_rob_id = 0;
        commit_en = 0; commit_rd = 0; commit_rob_id = 0; commit_value = 0;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        idle();
    endtask

    // Literal expectation on one read port (0 = rs1, 1 = rs2).
    task automatic lit(input bit port, input logic [4:0] idx, input string name,
                       input logic [31:0] ev, input bit eb, input logic [3:0] et);
        if (port) rs2 = idx; else rs1 = idx;
        #1;
        check({name, "_val"},  port ? rs2_val : rs1_val, ev);
        check({name, "_busy"}, {31'b0, port ? rs2_busy : rs1_busy}, {31'b0, eb});
        if (eb) check({name, "_tag"}, {28'b0, port ? rs2_tag : rs1_tag}, {28'b0, et});
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic [3:0] id);
        issue_en = 1; issue_rd = rd; issue_rob_id = id;
    endtask

    task automatic do_commit(input logic [4:0] rd, input logic [3:0] id, input logic [31:0] v);
        commit_en = 1; commit_rd = rd; commit_rob_id = id; commit_value = v;
    endtask

    initial begin
        idle(); rs1 = 0; rs2 = 0;
        #1;
        rst_in = 1; tick();
        rst_in = 1; tick();
        model_ok = 1;

        lit(0, 7, "rst_x7", 0, 0, 0);
        lit(1, 0, "rst_x0", 0, 0, 0);

        do_issue(0, 5); do_commit(0, 5, 32'hFFFF_FFFF); tick();
        lit(0, 0, "x0_rs1", 0, 0, 0);
        lit(1, 0, "x0_rs2", 0, 0, 0);

        do_issue(5, 3); tick();
        lit(0, 5, "iss_x5", 0, 1, 3);
        do_commit(5, 3, 32'h1234); tick();
        lit(0, 5, "cmt_x5", 32'h1234, 0, 0);

        do_issue(5, 3); tick();
        do_issue(5, 4); tick();
        do_commit(5, 3, 32'hAA); tick();
        lit(0, 5, "old_cmt_x5", 32'hAA, 1, 4);
        do_commit(5, 4, 32'hBB); tick();
        lit(0, 5, "new_cmt_x5", 32'hBB, 0, 0);

        do_issue(9, 2); tick();
        do_issue(9, 6); do_commit(9, 2, 32'h55); tick();
        lit(1, 9, "same_x9", 32'h55, 1, 6);

        for (int i = 1; i <= 4; i++) begin
            do_issue(i[4:0], 4'(i - 1)); tick();
        end
        lit(0, 3, "pre_flush_x3", 0, 1, 2);
        flush_in = 1; do_commit(2, 1, 32'h77); do_issue(8, 4); tick();
        lit(0, 2, "fl_x2", 32'h77, 0, 0);
        lit(1, 8, "fl_x8", 0, 0, 0);
        lit(0, 1, "fl_x1", 0, 0, 0);
        lit(1, 4, "fl_x4", 0, 0, 0);
        lit(0, 9, "fl_x9", 32'h55, 0, 0);

        for (int i = 0; i < 2; i++) begin
            rdy_in = 0; do_issue(3, 7); do_commit(3, 7, 32'h99); tick();
        end
        lit(0, 3, "hold_x3", 0, 0, 0);

        do_issue(10, 5); tick();
        do_commit(10, 5, 32'hDEAD);
`ifdef REG_BYPASS_EN
        lit(1, 10, "byp_same", 32'hDEAD, 0, 0);
`else
        lit(1, 10, "byp_same", 0, 1, 5);
`endif
        tick();
        lit(1, 10, "byp_next", 32'hDEAD, 0, 0);

        do_issue(11, 9); tick();
        rst_in = 1; rdy_in = 0; do_issue(12, 1); tick();
        lit(0, 10, "rst2_x10", 0, 0, 0);
        lit(1, 11, "rst2_x11", 0, 0, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_status_file.md
Name: reg_status_file

Overview:
- Architectural register file plus per-register rename status (busy bit, ROB tag) for the RV32I out-of-order core.
- Decoder-side read ports give operand value or producing ROB tag.
- The issue port marks the destination register busy with a newly allocated ROB id.
- Commit port, driven by the ROB head retire, writes architectural values and releases tags; flush clears all rename state on mispredict.

Parameters:
- REG_ID_BIT, 5, register index width (32 registers).
- ROB_WIDTH_BIT, 4, ROB tag width (16 entries).

Ports:
- clk_in  input  1  clock, all state updates on rising edge
- rst_in  input  1  synchronous reset, active-high
- rdy_in  input  1  pause when low; no state change
- issue_en  input  1  decoder issues an instruction writing a register this cycle
- issue_rd  input  REG_ID_BIT  destination register of issued instruction
- issue_rob_id  input  ROB_WIDTH_BIT  ROB entry allocated to it (tail)
- rs1  input  REG_ID_BIT  read port 1 index
- rs2  input  REG_ID_BIT  read port 2 index
- rs1_val  output  32  register value
- rs1_busy  output  1  value pending in ROB
- rs1_tag  output  ROB_WIDTH_BIT  producing ROB id, valid when rs1_busy
- rs2_val, rs2_busy, rs2_tag  outputs  32/1/ROB_WIDTH_BIT  same for port 2
- commit_en  input  1  ROB retires a register-writing entry
- commit_rd  input  REG_ID_BIT  retiring destination
- commit_rob_id  input  ROB_WIDTH_BIT  retiring entry id
- commit_value  input  32  retiring result
- flush_in  input  1  branch mispredict: discard all speculative renames

Behaviour:
- State: regs[0..31] 32b, busy[0..31], tag[0..31].
- Reset (rst_in=1 at edge): all regs=0, busy=0, tag=0, regardless of rdy_in or other inputs. After reset, read outputs are val=0, busy=0, tag=0 for every index.
- rdy_in=0 and not reset: hold all state; read ports remain live.
- Read ports: combinational from current state; no latency.
  - Index 0 always returns val=0, busy=0, tag=0.
  - An issue in the same cycle does not affect reads, so an instruction reads its sources before renaming rd (e.g. addi x5,x5,1 sees old x5 status).
- Commit (commit_en, commit_rd!=0): regs[commit_rd] <= commit_value next edge. Busy is cleared only if busy[commit_rd] && tag[commit_rd]==commit_rob_id; otherwise a younger renamer holds the register and busy/tag are untouched.
- Issue (issue_en, issue_rd!=0, no flush): busy[issue_rd] <= 1, tag[issue_rd] <= issue_rob_id.
- Issue and commit to the same rd in one cycle: value written, issue wins busy/tag (busy=1, tag=issue_rob_id), even if the commit tag matched.
- Flush: all busy <= 0 next edge; tags unchanged (don't-care).
  - A commit in the same cycle still writes its value, since it is older than the branch.
  - An issue in the same cycle is dropped.
- Writes to x0 ignored for value, busy and tag.
- Tag wrap: tags are compared exactly, with no age logic. The ROB guarantees a tag is never reallocated while the older holder is uncommitted.

Optional Feature:
- REG_BYPASS_EN
- Defined: a read port returns commit_value with busy=0 when all of the following hold in the same cycle:
  - commit_en=1
  - commit_rd equals the port index
  - the index is nonzero
  - busy for that index is 1
  - tag for that index equals commit_rob_id
- This saves one cycle of dependency wait.
- Undefined: reads reflect only registered state. The commit becomes visible one cycle later.

Test Plan:
- Reset then read rs1=7, rs2=0 -> val=0, busy=0 on both; write attempts to x0 (issue and commit value 0xFFFF_FFFF) -> x0 still 0, not busy.
- Issue rd=5 rob_id=3; next cycle rs1=5 -> busy=1, tag=3. Commit rd=5 rob_id=3 value=0x1234 -> next cycle val=0x1234, busy=0.
- Issue rd=5 id=3, then issue rd=5 id=4, then commit rd=5 id=3 value=0xAA -> val=0xAA, busy=1, tag=4. Commit id=4 value=0xBB -> val=0xBB, busy=0.
- Issue rd=9 id=6 and commit rd=9 id=2 value=0x55 in the same cycle (busy tag 2 beforehand) -> val=0x55, busy=1, tag=6.
- Issue rd=1..4 ids 0..3; flush with a simultaneous commit rd=2 id=1 value=0x77 and issue rd=8 id=4 -> all busy=0, x2=0x77, x8 not busy. Then hold rdy_in=0 with an issue asserted -> no change.
- REG_BYPASS_EN: x10 busy tag 5; commit rd=10 id=5 value=0xDEAD while reading rs2=10 -> same cycle rs2_val=0xDEAD, rs2_busy=0. Without the macro: rs2_busy=1 that cycle, value visible the next cycle.
